cube_move_sequencer: RTL and testbench

//  Owns the 162-bit cube state register; arbitrates move requests from init, undo, scramble and manual sources.

---
 rtl/cube_pkg.sv | 55 +++++
 rtl/cube_move_sequencer_if.sv | 55 +++++
 rtl/move_hist_lifo.sv | 64 ++++++
 rtl/cube_move_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_cube_move_sequencer.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cube_pkg.sv
// cube_pkg
// Shared definitions for the cube move sequencer slice.
//   - face codes (U,L,F,R,B,D = 0..5) and quarter-turn rotation codes
//   - sequencer FSM states
//   - SOLVED_CUBE: 54 stickers x 3 bits, sticker i holds colour i/9
//   - inv_rot(): rotation that cancels a given rotation, (4-r)&3
//   - face_legal(): faces 6 and 7 are treated as no-op moves
package cube_pkg;

    localparam int CUBE_W = 162;

    typedef enum logic [2:0] {
        FACE_U = 3'd0,
        FACE_L = 3'd1,
        FACE_F = 3'd2,
        FACE_R = 3'd3,
        FACE_B = 3'd4,
        FACE_D = 3'd5
    } face_t;

    typedef enum logic [1:0] {
        ROT_NONE = 2'd0,
        ROT_CW   = 2'd1,
        ROT_DBL  = 2'd2,
        ROT_CCW  = 2'd3
    } rot_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_APPLY,
        ST_CHECK
    } state_t;

    // One history entry: the manual move exactly as it was applied.
    typedef struct packed {
        logic [2:0] face;
        logic [1:0] rot;
    } hist_entry_t;

    // Face 5 occupies the top 27 bits, face 0 the bottom 27 bits.
    localparam logic [CUBE_W-1:0] SOLVED_CUBE = {
        {9{3'd5}}, {9{3'd4}}, {9{3'd3}}, {9{3'd2}}, {9{3'd1}}, {9{3'd0}}
    };

    // Two-bit subtraction from zero wraps to (4-r)&3.
    function automatic logic [1:0] inv_rot(input logic [1:0] r);
        return 2'd0 - r;
    endfunction

    function automatic logic face_legal(input logic [2:0] f);
        return f <= FACE_D;
    endfunction

endpackage

// File: rtl/cube_move_sequencer_if.sv
// cube_move_sequencer_if
// Bundles the request handshakes, the external move-engine link and the
// status outputs of the cube move sequencer.
//   master : front-end / engine side (drives valids, move fields, eng_next)
//   slave  : the sequencer (drives readies, engine operands, cube state, status)
// Signals:
//   init/undo/scr/man _valid, _ready : request handshakes
//   scr_face/scr_rot, man_face/man_rot : move operands
//   eng_face, eng_rot, eng_next        : external combinational move engine
//   cube_state, solved, move_count, hist_depth, undo_empty, busy : status
interface cube_move_sequencer_if
    import cube_pkg::*;
#(
    parameter int HIST_DEPTH = 64
) ();

    localparam int DEPTH_W = $clog2(HIST_DEPTH) + 1;

    logic               init_valid;
    logic               init_ready;
    logic               undo_valid;
    logic               undo_ready;
    logic               scr_valid;
    logic [2:0]         scr_face;
    logic [1:0]         scr_rot;
    logic               scr_ready;
    logic               man_valid;
    logic [2:0]         man_face;
    logic [1:0]         man_rot;
    logic               man_ready;
    logic [5:0]         eng_face;
    logic [2:0]         eng_rot;
    logic [CUBE_W-1:0]  eng_next;
    logic [CUBE_W-1:0]  cube_state;
    logic               solved;
    logic [9:0]         move_count;
    logic [DEPTH_W-1:0] hist_depth;
    logic               undo_empty;
    logic               busy;

    modport master (
        output init_valid, undo_valid, scr_valid, scr_face, scr_rot,
               man_valid, man_face, man_rot, eng_next,
        input  init_ready, undo_ready, scr_ready, man_ready, eng_face, eng_rot,
               cube_state, solved, move_count, hist_depth, undo_empty, busy
    );

    modport slave (
        input  init_valid, undo_valid, scr_valid, scr_face, scr_rot,
               man_valid, man_face, man_rot, eng_next,
        output init_ready, undo_ready, scr_ready, man_ready, eng_face, eng_rot,
               cube_state, solved, move_count, hist_depth, undo_empty, busy
    );

endinterface

// File: rtl/move_hist_lifo.sv
// move_hist_lifo
// Circular LIFO of manual moves. Pushing into a full stack overwrites the
// oldest entry, so the stack always holds the most recent DEPTH moves.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   push, pop  : push_data onto / remove top entry (pop ignored when empty)
//   clear      : discard all entries (wins over push and pop)
//   push_data  : entry to store
//   top_data   : most recently pushed entry still held (valid when depth>0)
//   depth      : number of valid entries, 0..DEPTH
module move_hist_lifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top_data,
    output logic [$clog2(DEPTH):0]   depth
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    top_ptr;
    logic [CW-1:0]    count;

    // Storage has no reset; only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The write pointer wraps freely (DEPTH is a power of two), which is what
    // turns a push on a full stack into an overwrite of the oldest entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop && count != '0) begin
            wr_ptr <= wr_ptr - AW'(1);
            count  <= count - CW'(1);
        end
    end

    assign top_ptr  = wr_ptr - AW'(1);
    assign top_data = mem[top_ptr];
    assign depth    = count;

endmodule

// File: rtl/cube_move_sequencer.sv
// cube_move_sequencer
// Owns the committed cube state and arbitrates init, undo, scramble and
// manual move requests (fixed priority init > undo > scr > man). Each granted
// move goes through the external combinational move engine for one APPLY
// cycle, then solved is re-evaluated in CHECK. Manual moves are kept in a
// history stack so undo can apply the inverse move.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : cube_move_sequencer_if.slave (handshakes, engine link, status)
module cube_move_sequencer
    import cube_pkg::*;
#(
    parameter int HIST_DEPTH = 64,
    parameter int MAX_COUNT  = 999
) (
    input  logic                   clk,
    input  logic                   rst,
    cube_move_sequencer_if.slave   bus
);

    localparam int          DEPTH_W   = $clog2(HIST_DEPTH) + 1;
    localparam logic [9:0]  COUNT_MAX = 10'(MAX_COUNT);

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         op_face;
    logic [2:0]         op_face_nxt;
    logic [1:0]         op_rot;
    logic [1:0]         op_rot_nxt;
    logic               grant_init;
    logic               grant_undo;
    logic               grant_scr;
    logic               grant_man;
    logic               lifo_push;
    logic               lifo_pop;
    logic               lifo_clear;
    hist_entry_t        lifo_top;
    logic [4:0]         lifo_top_bits;
    logic [DEPTH_W-1:0] depth;
    logic [5:0]         eng_face;
    logic [2:0]         eng_rot;
    logic [CUBE_W-1:0]  cube;
    logic               solved;
    logic [9:0]         move_count;
    logic               undo_empty;
    logic               man_real;

    move_hist_lifo #(
        .DEPTH (HIST_DEPTH),
        .WIDTH (5)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .push      (lifo_push),
        .pop       (lifo_pop),
        .clear     (lifo_clear),
        .push_data ({bus.man_face, bus.man_rot}),
        .top_data  (lifo_top_bits),
        .depth     (depth)
    );

    assign lifo_top = hist_entry_t'(lifo_top_bits);

    // A manual move only counts and enters history when it actually turns
    // a real face.
    assign man_real = face_legal(bus.man_face) && (bus.man_rot != ROT_NONE);

    // State register; reset restarts the sequencer in INIT, aborting any op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, arbitration and per-state controls. Readies depend only on
    // the valids and the state, never on eng_next. Illegal faces and empty
    // undos still walk APPLY/CHECK, but with rotation 0 so the engine returns
    // the cube unchanged.
    always_comb begin
        state_nxt   = state;
        op_face_nxt = op_face;
        op_rot_nxt  = op_rot;
        grant_init  = 1'b0;
        grant_undo  = 1'b0;
        grant_scr   = 1'b0;
        grant_man   = 1'b0;
        lifo_push   = 1'b0;
        lifo_pop    = 1'b0;
        lifo_clear  = 1'b0;
        eng_face    = 6'd0;
        eng_rot     = 3'd0;
        case (state)
            ST_INIT: begin
                lifo_clear = 1'b1;
                state_nxt  = ST_CHECK;
            end
            ST_IDLE: begin
                if (bus.init_valid) begin
                    grant_init = 1'b1;
                    state_nxt  = ST_INIT;
                end else if (bus.undo_valid) begin
                    grant_undo = 1'b1;
                    state_nxt  = ST_APPLY;
                    if (depth != '0) begin
                        op_face_nxt = lifo_top.face;
                        op_rot_nxt  = inv_rot(lifo_top.rot);
                        lifo_pop    = 1'b1;
                    end else begin
                        op_face_nxt = FACE_U;
                        op_rot_nxt  = ROT_NONE;
                    end
                end else if (bus.scr_valid) begin
                    grant_scr   = 1'b1;
                    state_nxt   = ST_APPLY;
                    lifo_clear  = 1'b1;
                    op_face_nxt = bus.scr_face;
                    op_rot_nxt  = face_legal(bus.scr_face) ? bus.scr_rot : ROT_NONE;
                end else if (bus.man_valid) begin
                    grant_man   = 1'b1;
                    state_nxt   = ST_APPLY;
                    lifo_push   = man_real;
                    op_face_nxt = bus.man_face;
                    op_rot_nxt  = man_real ? bus.man_rot : ROT_NONE;
                end
            end
            ST_APPLY: begin
                eng_face  = {3'b000, op_face};
                eng_rot   = {1'b0, op_rot};
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Datapath registers: latched op, committed cube, solved flag, net move
    // count and the one-cycle empty-undo pulse. Scramble resets the count
    // because scramble moves are never undoable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_face    <= 3'd0;
            op_rot     <= 2'd0;
            cube       <= '0;
            solved     <= 1'b0;
            move_count <= 10'd0;
            undo_empty <= 1'b0;
        end else begin
            op_face    <= op_face_nxt;
            op_rot     <= op_rot_nxt;
            undo_empty <= grant_undo && (depth == '0);
            case (state)
                ST_INIT: begin
                    cube       <= SOLVED_CUBE;
                    move_count <= 10'd0;
                end
                ST_IDLE: begin
                    if (grant_scr) begin
                        move_count <= 10'd0;
                    end else if (lifo_push && move_count != COUNT_MAX) begin
                        move_count <= move_count + 10'd1;
                    end else if (lifo_pop && move_count != 10'd0) begin
                        move_count <= move_count - 10'd1;
                    end
                end
                ST_APPLY: begin
                    cube <= bus.eng_next;
                end
                ST_CHECK: begin
                    solved <= (cube == SOLVED_CUBE);
                end
                default: begin
                    cube <= cube;
                end
            endcase
        end
    end

    assign bus.init_ready = grant_init;
    assign bus.undo_ready = grant_undo;
    assign bus.scr_ready  = grant_scr;
    assign bus.man_ready  = grant_man;
    assign bus.eng_face   = eng_face;
    assign bus.eng_rot    = eng_rot;
    assign bus.cube_state = cube;
    assign bus.solved     = solved;
    assign bus.move_count = move_count;
    assign bus.hist_depth = depth;
    assign bus.undo_empty = undo_empty;
    assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_cube_move_sequencer.sv
// tb_cube_move_sequencer
// Self-checking bench for cube_move_sequencer. Provides a stand-in move
// engine (each face quarter-turn cycles 3-sticker strips around the four
// neighbouring faces, order 4) and a reference model holding the cube,
// a history queue and the move count.
module tb_cube_move_sequencer;

    logic clk;
    logic rst;

    cube_move_sequencer_if bus ();

    cube_move_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           n_checks;
    int           n_fail;
    logic [161:0] solved_ref;
    logic [161:0] m_cube;
    int           m_hist[$];
    int           m_count;
    logic         m_solved;
    logic         m_empty;
    logic         last_empty;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Quarter turn of face f: strip k=0..2 of neighbour face n_j moves to n_{j+1}.
    function automatic logic [161:0] quarter(input logic [161:0] s, input int f);
        logic [161:0] r;
        int src;
        int dst;
        r = s;
        for (int j = 0; j < 4; j++) begin
            src = (f + 1 + j) % 6;
            dst = (f + 1 + ((j + 1) % 4)) % 6;
            for (int k = 0; k < 3; k++) begin
                r[3*(9*dst+k) +: 3] = s[3*(9*src+k) +: 3];
            end
        end
        return r;
    endfunction

    function automatic logic [161:0] engine(input logic [161:0] s, input int f, input int rot);
        logic [161:0] r;
        r = s;
        if (f <= 5) begin
            for (int i = 0; i < rot; i++) begin
                r = quarter(r, f);
            end
        end
        return r;
    endfunction

    always_comb begin
        bus.eng_next = engine(bus.cube_state, int'(bus.eng_face), int'(bus.eng_rot));
    end

    // Reference behaviour of one granted operation. kind: 0 init, 1 undo, 2 scramble, 3 manual.
    task automatic model_op(input int kind, input int face, input int rot);
        int e;
        m_empty = 1'b0;
        case (kind)
            0: begin
                m_cube = solved_ref;
                m_hist.delete();
                m_count = 0;
            end
            1: begin
                if (m_hist.size() > 0) begin
                    e = m_hist.pop_back();
                    m_cube = engine(m_cube, e / 4, (4 - (e % 4)) % 4);
                    if (m_count > 0) m_count--;
                end else begin
                    m_empty = 1'b1;
                end
            end
            2: begin
                if (face <= 5) m_cube = engine(m_cube, face, rot);
                m_hist.delete();
                m_count = 0;
            end
            default: begin
                if (face <= 5 && rot != 0) begin
                    m_cube = engine(m_cube, face, rot);
                    m_hist.push_back(face * 4 + rot);
                    if (m_hist.size() > 64) void'(m_hist.pop_front());
                    if (m_count < 999) m_count++;
                end
            end
        endcase
        m_solved = (m_cube == solved_ref);
    endtask

    function automatic logic ready_of(input int kind);
        case (kind)
            0:       return bus.init_ready;
            1:       return bus.undo_ready;
            2:       return bus.scr_ready;
            default: return bus.man_ready;
        endcase
    endfunction

    task automatic drop_valids();
        bus.init_valid = 1'b0;
        bus.undo_valid = 1'b0;
        bus.scr_valid  = 1'b0;
        bus.man_valid  = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (bus.busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (bus.busy) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL idle_timeout busy=%0d required 0", bus.busy);
        end
    endtask

    // Issue one request, hold it until granted, then follow it back to IDLE.
    task automatic do_op(input int kind, input int face, input int rot);
        int cyc;
        @(negedge clk);
        case (kind)
            0: bus.init_valid = 1'b1;
            1: bus.undo_valid = 1'b1;
            2: begin
                bus.scr_face  = 3'(face);
                bus.scr_rot   = 2'(rot);
                bus.scr_valid = 1'b1;
            end
            default: begin
                bus.man_face  = 3'(face);
                bus.man_rot   = 2'(rot);
                bus.man_valid = 1'b1;
            end
        endcase
        #1;
        cyc = 0;
        while (!ready_of(kind) && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!ready_of(kind)) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL grant_timeout kind=%0d ready=0 required 1", kind);
        end
        @(posedge clk);
        #1;
        drop_valids();
        last_empty = bus.undo_empty;
        model_op(kind, face, rot);
        wait_idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drop_valids();
        bus.scr_face = 3'd0;
        bus.scr_rot  = 2'd0;
        bus.man_face = 3'd0;
        bus.man_rot  = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.cube_state !== 162'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_cube got %h required 0", bus.cube_state);
        end
        n_checks++;
        if ({bus.solved, bus.move_count, bus.hist_depth, bus.undo_empty} !== 19'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_status solved=%0d count=%0d depth=%0d empty=%0d required all 0",
                     bus.solved, bus.move_count, bus.hist_depth, bus.undo_empty);
        end
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_busy got %0d required 1", bus.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        model_op(0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.cube_state !== solved_ref || bus.solved !== 1'b1 || bus.busy !== 1'b0 || bus.hist_depth !== 7'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_release cube=%h solved=%0d busy=%0d depth=%0d required solved cube,1,0,0",
                     bus.cube_state, bus.solved, bus.busy, bus.hist_depth);
        end
    endtask

    task automatic test_man_undo();
        do_op(3, 2, 1);
        n_checks++;
        if (bus.move_count !== 10'd1 || bus.hist_depth !== 7'd1 || bus.cube_state !== m_cube || bus.solved !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL man_move count=%0d depth=%0d solved=%0d cube=%h required 1,1,0,%h",
                     bus.move_count, bus.hist_depth, bus.solved, bus.cube_state, m_cube);
        end
        do_op(1, 0, 0);
        n_checks++;
        if (bus.move_count !== 10'd0 || bus.hist_depth !== 7'd0 || bus.cube_state !== solved_ref ||
            bus.solved !== 1'b1 || last_empty !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL man_undo count=%0d depth=%0d solved=%0d empty=%0d cube=%h required 0,0,1,0,solved",
                     bus.move_count, bus.hist_depth, bus.solved, last_empty, bus.cube_state);
        end
    endtask

    task automatic test_priority();
        int g_undo;
        int g_scr;
        int g_man;
        int sf;
        int sr;
        int mf;
        int mr;
        logic [3:0] rdy;
        g_undo = -1;
        g_scr  = -1;
        g_man  = -1;
        sf = int'($urandom_range(5, 0));
        sr = int'($urandom_range(3, 0));
        mf = int'($urandom_range(5, 0));
        mr = int'($urandom_range(3, 1));
        @(negedge clk);
        bus.scr_face   = 3'(sf);
        bus.scr_rot    = 2'(sr);
        bus.man_face   = 3'(mf);
        bus.man_rot    = 2'(mr);
        bus.init_valid = 1'b1;
        bus.undo_valid = 1'b1;
        bus.scr_valid  = 1'b1;
        bus.man_valid  = 1'b1;
        #1;
        rdy = {bus.init_ready, bus.undo_ready, bus.scr_ready, bus.man_ready};
        n_checks++;
        if (rdy !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL prio_all_valid readies=%b required 1000", rdy);
        end
        @(posedge clk);
        #1;
        bus.init_valid = 1'b0;
        model_op(0, 0, 0);
        for (int c = 1; c <= 15 && g_man < 0; c++) begin
            @(negedge clk);
            #1;
            rdy = {bus.init_ready, bus.undo_ready, bus.scr_ready, bus.man_ready};
            if (rdy != 4'b0000) begin
                n_checks++;
                if (g_undo < 0) begin
                    g_undo = c;
                    if (rdy !== 4'b0100) begin
                        n_fail++;
                        $display("[TB] FAIL prio_undo readies=%b required 0100", rdy);
                    end
                    @(posedge clk);
                    #1;
                    bus.undo_valid = 1'b0;
                    model_op(1, 0, 0);
                    n_checks++;
                    if (bus.undo_empty !== m_empty) begin
                        n_fail++;
                        $display("[TB] FAIL prio_undo_empty got %0d required %0d", bus.undo_empty, m_empty);
                    end
                end else if (g_scr < 0) begin
                    g_scr = c;
                    if (rdy !== 4'b0010) begin
                        n_fail++;
                        $display("[TB] FAIL prio_scr readies=%b required 0010", rdy);
                    end
                    @(posedge clk);
                    #1;
                    bus.scr_valid = 1'b0;
                    model_op(2, sf, sr);
                end else begin
                    g_man = c;
                    if (rdy !== 4'b0001) begin
                        n_fail++;
                        $display("[TB] FAIL prio_man readies=%b required 0001", rdy);
                    end
                    @(posedge clk);
                    #1;
                    bus.man_valid = 1'b0;
                    model_op(3, mf, mr);
                end
            end
        end
        drop_valids();
        wait_idle();
        n_checks++;
        if (g_undo !== 3 || g_scr !== 6 || g_man !== 9) begin
            n_fail++;
            $display("[TB] FAIL prio_spacing grants at %0d,%0d,%0d required 3,6,9", g_undo, g_scr, g_man);
        end
        n_checks++;
        if (bus.cube_state !== m_cube || bus.move_count !== 10'(m_count) || bus.hist_depth !== 7'(m_hist.size())) begin
            n_fail++;
            $display("[TB] FAIL prio_result cube=%h count=%0d depth=%0d required %h,%0d,%0d",
                     bus.cube_state, bus.move_count, bus.hist_depth, m_cube, m_count, m_hist.size());
        end
    endtask

    task automatic test_hist_wrap();
        int peak;
        int bad_pulses;
        peak = 0;
        bad_pulses = 0;
        do_op(0, 0, 0);
        for (int i = 0; i < 65; i++) begin
            do_op(3, 3, 1);
            if (int'(bus.hist_depth) > peak) peak = int'(bus.hist_depth);
        end
        n_checks++;
        if (peak !== 64 || bus.hist_depth !== 7'd64 || bus.move_count !== 10'd65) begin
            n_fail++;
            $display("[TB] FAIL wrap_fill peak=%0d depth=%0d count=%0d required 64,64,65",
                     peak, bus.hist_depth, bus.move_count);
        end
        for (int i = 0; i < 64; i++) begin
            do_op(1, 0, 0);
            if (last_empty !== 1'b0) bad_pulses++;
        end
        do_op(1, 0, 0);
        n_checks++;
        if (bad_pulses !== 0 || last_empty !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wrap_empty_pulse early=%0d last=%0d required 0,1", bad_pulses, last_empty);
        end
        n_checks++;
        if (bus.cube_state !== engine(solved_ref, 3, 1) || bus.cube_state !== m_cube ||
            bus.hist_depth !== 7'd0 || bus.move_count !== 10'd1) begin
            n_fail++;
            $display("[TB] FAIL wrap_unwind cube=%h depth=%0d count=%0d required %h,0,1",
                     bus.cube_state, bus.hist_depth, bus.move_count, engine(solved_ref, 3, 1));
        end
    endtask

    task automatic test_scramble();
        logic [161:0] scrambled;
        do_op(0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            do_op(2, int'($urandom_range(5, 0)), int'($urandom_range(3, 0)));
        end
        scrambled = m_cube;
        do_op(3, int'($urandom_range(5, 0)), int'($urandom_range(3, 1)));
        n_checks++;
        if (bus.move_count !== 10'd1 || bus.cube_state !== m_cube) begin
            n_fail++;
            $display("[TB] FAIL scr_man count=%0d cube=%h required 1,%h", bus.move_count, bus.cube_state, m_cube);
        end
        do_op(1, 0, 0);
        n_checks++;
        if (bus.move_count !== 10'd0 || last_empty !== 1'b0 || bus.cube_state !== scrambled) begin
            n_fail++;
            $display("[TB] FAIL scr_undo count=%0d empty=%0d cube=%h required 0,0,%h",
                     bus.move_count, last_empty, bus.cube_state, scrambled);
        end
        do_op(1, 0, 0);
        n_checks++;
        if (last_empty !== 1'b1 || bus.cube_state !== scrambled || bus.move_count !== 10'd0 || bus.hist_depth !== 7'd0) begin
            n_fail++;
            $display("[TB] FAIL scr_undo_empty empty=%0d count=%0d depth=%0d cube=%h required 1,0,0,%h",
                     last_empty, bus.move_count, bus.hist_depth, bus.cube_state, scrambled);
        end
    endtask

    task automatic test_reset_apply();
        int cyc;
        @(negedge clk);
        bus.man_face  = 3'd1;
        bus.man_rot   = 2'd2;
        bus.man_valid = 1'b1;
        #1;
        cyc = 0;
        while (!bus.man_ready && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        @(posedge clk);
        #1;
        bus.man_valid = 1'b0;
        #2;
        rst = 1'b0;
        bus.init_valid = 1'b1;
        bus.undo_valid = 1'b1;
        bus.scr_valid  = 1'b1;
        bus.man_valid  = 1'b1;
        #1;
        n_checks++;
        if (bus.cube_state !== 162'd0 || bus.solved !== 1'b0 || bus.move_count !== 10'd0 ||
            bus.hist_depth !== 7'd0 || bus.busy !== 1'b1 || bus.undo_empty !== 1'b0 ||
            {bus.init_ready, bus.undo_ready, bus.scr_ready, bus.man_ready} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL rst_in_apply cube=%h solved=%0d count=%0d depth=%0d busy=%0d readies=%b required reset values",
                     bus.cube_state, bus.solved, bus.move_count, bus.hist_depth, bus.busy,
                     {bus.init_ready, bus.undo_ready, bus.scr_ready, bus.man_ready});
        end
        drop_valids();
        @(negedge clk);
        rst = 1'b1;
        model_op(0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.cube_state !== solved_ref || bus.solved !== 1'b1 || bus.busy !== 1'b0 || bus.hist_depth !== 7'd0) begin
            n_fail++;
            $display("[TB] FAIL rst_recover cube=%h solved=%0d busy=%0d depth=%0d required solved,1,0,0",
                     bus.cube_state, bus.solved, bus.busy, bus.hist_depth);
        end
    endtask

    task automatic test_saturation();
        do_op(0, 0, 0);
        for (int i = 0; i < 1001; i++) begin
            do_op(3, int'($urandom_range(5, 0)), int'($urandom_range(3, 1)));
            if (i == 997) begin
                n_checks++;
                if (bus.move_count !== 10'd998) begin
                    n_fail++;
                    $display("[TB] FAIL sat_below count=%0d required 998", bus.move_count);
                end
            end
        end
        n_checks++;
        if (bus.move_count !== 10'd999 || bus.hist_depth !== 7'd64 || bus.cube_state !== m_cube) begin
            n_fail++;
            $display("[TB] FAIL sat_count count=%0d depth=%0d cube=%h required 999,64,%h",
                     bus.move_count, bus.hist_depth, bus.cube_state, m_cube);
        end
    endtask

    task automatic test_random();
        int k;
        int kind;
        int face;
        int rot;
        do_op(0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            k = int'($urandom_range(19, 0));
            if (k == 0) kind = 0;
            else if (k <= 6) kind = 1;
            else if (k == 7) kind = 2;
            else kind = 3;
            face = (kind == 2) ? int'($urandom_range(5, 0)) : int'($urandom_range(7, 0));
            rot  = int'($urandom_range(3, 0));
            do_op(kind, face, rot);
            n_checks++;
            if (bus.cube_state !== m_cube || bus.move_count !== 10'(m_count) ||
                bus.hist_depth !== 7'(m_hist.size()) || bus.solved !== m_solved || last_empty !== m_empty) begin
                n_fail++;
                $display("[TB] FAIL random_op%0d kind=%0d face=%0d rot=%0d got cube=%h count=%0d depth=%0d solved=%0d empty=%0d required %h,%0d,%0d,%0d,%0d",
                         i, kind, face, rot, bus.cube_state, bus.move_count, bus.hist_depth, bus.solved, last_empty,
                         m_cube, m_count, m_hist.size(), m_solved, m_empty);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 54; i++) begin
            solved_ref[3*i +: 3] = 3'(i / 9);
        end
        test_reset();
        test_man_undo();
        test_priority();
        test_hist_wrap();
        test_scramble();
        test_reset_apply();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
